// File: rtl/get_cert_sequencer_pkg.sv
// Shared types for the GET_CERTIFICATE sequencer: FSM state encoding and
// the slot constants also used by the certificate generator.
package get_cert_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_GEN       = 2'd1,
      ST_SEND      = 2'd2,
      ST_WAIT_RESP = 2'd3
   } state_t;

   localparam logic [1:0] SLOT0 = 2'd0;
   localparam logic [1:0] SLOT1 = 2'd1;
   localparam logic [1:0] SLOT2 = 2'd2;

   function automatic logic slot_is_valid(input logic [1:0] slot);
      return (slot <= SLOT2);
   endfunction

endpackage

// File: rtl/get_cert_timeout_timer.sv
// Response timeout timer: loaded on entry to the wait, counts down while
// enabled and flags expiry on the terminal count.
module get_cert_timeout_timer #(
   parameter int unsigned CYCLES = 1000,
   parameter int unsigned W      = 10
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_load,
   input  logic i_count,
   output logic o_expire
);

   localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= LOAD_VAL;
      end else if (i_count && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   // Terminal count reached on the CYCLES-th counting cycle after a load.
   assign o_expire = i_count && (r_count == '0);

endmodule

// File: rtl/get_cert_sequencer.sv
// Walks the certificate generator through every certificate of one slot,
// handing each message to the transmitter and retrying on NAK or timeout.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | waiting for start; all generator/transmitter outputs low
//  GEN       | generator enabled, waiting for its header/payload (Ack_out)
//  SEND      | message offered to the transmitter until accepted
//  WAIT_RESP | waiting for the responder's reply, timeout timer running
module get_cert_sequencer
   import get_cert_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned MAX_RETRIES    = 2,
   parameter int unsigned TO_W           = 10
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [1:0] i_slot_in,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_error,
   output logic       o_gen_enable,
   output logic [1:0] o_gen_slot,
   output logic [7:0] o_gen_counter,
   output logic       o_gen_ack_in,
   input  logic       i_gen_ack_out,
   input  logic [7:0] i_expected_certs,
   output logic       o_msg_valid,
   input  logic       i_msg_ready,
   input  logic       i_resp_valid,
   input  logic       i_resp_ok
);

   localparam int unsigned       RTRY_W   = $clog2(MAX_RETRIES + 1);
   localparam logic [RTRY_W-1:0] RTRY_MAX = RTRY_W'(MAX_RETRIES);

   state_t            r_state,    w_state_nxt;
   logic [1:0]        r_slot,     w_slot_nxt;
   logic [7:0]        r_counter,  w_counter_nxt;
   logic [7:0]        r_expected, w_expected_nxt;
   logic [RTRY_W-1:0] r_retries,  w_retries_nxt;
   logic              r_done,     w_done_nxt;
   logic              r_error,    w_error_nxt;
   logic              r_ack_in,   w_ack_in_nxt;
   logic              w_timer_load;
   logic              w_timer_count;
   logic              w_expire;
   logic              w_resp_good;
   logic              w_resp_fail;

   get_cert_timeout_timer #(
      .CYCLES (TIMEOUT_CYCLES),
      .W      (TO_W)
   ) u_timer (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_load   (w_timer_load),
      .i_count  (w_timer_count),
      .o_expire (w_expire)
   );

   assign w_timer_count = (r_state == ST_WAIT_RESP);
   assign w_resp_good   = i_resp_valid && i_resp_ok;
   // A good reply beats a simultaneous timeout.
   assign w_resp_fail   = (i_resp_valid && !i_resp_ok) || (!i_resp_valid && w_expire);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_slot     <= '0;
         r_counter  <= '0;
         r_expected <= '0;
         r_retries  <= '0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_ack_in   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_slot     <= w_slot_nxt;
         r_counter  <= w_counter_nxt;
         r_expected <= w_expected_nxt;
         r_retries  <= w_retries_nxt;
         r_done     <= w_done_nxt;
         r_error    <= w_error_nxt;
         r_ack_in   <= w_ack_in_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_slot_nxt     = r_slot;
      w_counter_nxt  = r_counter;
      w_expected_nxt = r_expected;
      w_retries_nxt  = r_retries;
      w_done_nxt     = 1'b0;
      w_error_nxt    = 1'b0;
      w_ack_in_nxt   = 1'b0;
      w_timer_load   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               if (slot_is_valid(i_slot_in)) begin
                  w_slot_nxt    = i_slot_in;
                  w_counter_nxt = 8'd1;
                  w_retries_nxt = '0;
                  w_state_nxt   = ST_GEN;
               end else begin
                  w_error_nxt = 1'b1;
               end
            end
         end
         ST_GEN: begin
            if (i_gen_ack_out) begin
               // The chain length is only trusted from the first certificate.
               if (r_counter == 8'd1) begin
                  w_expected_nxt = i_expected_certs;
               end
               if ((r_counter == 8'd1) && (i_expected_certs == 8'd0)) begin
                  w_error_nxt = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_SEND;
               end
            end
         end
         ST_SEND: begin
            if (i_msg_ready) begin
               w_timer_load = 1'b1;
               w_state_nxt  = ST_WAIT_RESP;
            end
         end
         ST_WAIT_RESP: begin
            if (w_resp_good) begin
               if (r_counter == r_expected) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_counter_nxt = r_counter + 8'd1;
                  w_ack_in_nxt  = 1'b1;
                  w_retries_nxt = '0;
                  w_state_nxt   = ST_GEN;
               end
            end else if (w_resp_fail) begin
               // Resend without Ack_in so the generator keeps its offset.
               if (r_retries < RTRY_MAX) begin
                  w_retries_nxt = r_retries + RTRY_W'(1);
                  w_state_nxt   = ST_SEND;
               end else begin
                  w_error_nxt = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign o_busy        = (r_state != ST_IDLE);
   assign o_gen_enable  = (r_state != ST_IDLE);
   assign o_msg_valid   = (r_state == ST_SEND);
   assign o_done        = r_done;
   assign o_error       = r_error;
   assign o_gen_ack_in  = r_ack_in;
   assign o_gen_slot    = r_slot;
   assign o_gen_counter = r_counter;

endmodule

// File: tb/tb_get_cert_sequencer.sv
// Scoreboard bench for get_cert_sequencer: a chain-level reference model
// predicts the event sequence; a monitor pops and compares as events occur.
module tb_get_cert_sequencer;

   localparam int TO   = 1000;
   localparam int MAXR = 2;
   localparam int BUDGET = 20000;

   localparam int EV_XFER = 0, EV_ACK = 1, EV_DONE = 2, EV_ERR = 3;
   localparam int OC_OK = 0, OC_NAK = 1, OC_TO = 2, OC_LATE = 3;

   typedef struct {
      int kind;
      int cnt;
      int slot;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset, start, hold_ready;
   logic [1:0] slot_in;
   logic [7:0] expected_certs;
   logic       busy, done, error, gen_enable, gen_ack_in, msg_valid;
   logic [1:0] gen_slot;
   logic [7:0] gen_counter;
   logic       gen_ack_out, msg_ready, resp_valid, resp_ok;

   ev_t exp_q[$];
   int  plan_q[$];
   int  n_cmp = 0, n_bad = 0;
   int  cyc = 0, n_xfer = 0, n_ack = 0, n_done = 0;
   int  last_xfer_cyc = 0, last_err_cyc = 0;

   always #5 clk = ~clk;

   get_cert_sequencer #(
      .TIMEOUT_CYCLES (TO),
      .MAX_RETRIES    (MAXR),
      .TO_W           (10)
   ) dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_start          (start),
      .i_slot_in        (slot_in),
      .o_busy           (busy),
      .o_done           (done),
      .o_error          (error),
      .o_gen_enable     (gen_enable),
      .o_gen_slot       (gen_slot),
      .o_gen_counter    (gen_counter),
      .o_gen_ack_in     (gen_ack_in),
      .i_gen_ack_out    (gen_ack_out),
      .i_expected_certs (expected_certs),
      .o_msg_valid      (msg_valid),
      .i_msg_ready      (msg_ready),
      .i_resp_valid     (resp_valid),
      .i_resp_ok        (resp_ok)
   );

   task automatic chk(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // Environment: generator, transmitter and responder models, driven after each edge.
   bit gen_pend, en_q, resp_armed, resp_okv, xfer_prev;
   int gen_dly, resp_cnt;
   always @(posedge clk) begin
      #2;
      gen_ack_out = 1'b0;
      if (gen_pend) begin
         if (gen_dly == 0) begin
            gen_ack_out = 1'b1;
            gen_pend = 1'b0;
         end else gen_dly--;
      end
      if ((gen_enable && !en_q) || gen_ack_in) begin
         gen_pend = 1'b1;
         gen_dly = $urandom_range(0, 3);
      end
      en_q = gen_enable;

      resp_valid = 1'b0;
      resp_ok = 1'b0;
      if (xfer_prev && plan_q.size() > 0) begin
         int oc;
         oc = plan_q.pop_front();
         if (oc == OC_OK || oc == OC_NAK) begin
            resp_armed = 1'b1;
            resp_okv = (oc == OC_OK);
            resp_cnt = $urandom_range(0, 6);
         end else if (oc == OC_LATE) begin
            resp_armed = 1'b1;
            resp_okv = 1'b1;
            resp_cnt = TO - 1;
         end
      end
      if (resp_armed) begin
         if (resp_cnt == 0) begin
            resp_valid = 1'b1;
            resp_ok = resp_okv;
            resp_armed = 1'b0;
         end else resp_cnt--;
      end

      msg_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
      xfer_prev = msg_valid && msg_ready;
   end

   task automatic check_ev(input string name, input int kind, input int cnt, input int slot);
      ev_t e;
      if (exp_q.size() == 0) begin
         chk({"unexpected_", name}, kind, -1);
      end else begin
         e = exp_q.pop_front();
         chk({name, "_kind"}, kind, e.kind);
         chk({name, "_counter"}, cnt, e.cnt);
         chk({name, "_slot"}, slot, e.slot);
      end
   endtask

   // Monitor: every observable event is matched against the head of the scoreboard.
   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         if (msg_valid && msg_ready) begin
            n_xfer++;
            last_xfer_cyc = cyc;
            check_ev("xfer", EV_XFER, int'(gen_counter), int'(gen_slot));
         end
         if (gen_ack_in) begin
            n_ack++;
            check_ev("ack_in", EV_ACK, int'(gen_counter), int'(gen_slot));
         end
         if (done) begin
            n_done++;
            check_ev("done", EV_DONE, 0, 0);
         end
         if (error) begin
            last_err_cyc = cyc;
            check_ev("error", EV_ERR, 0, 0);
         end
         if (done || error) begin
            chk("busy_at_end", int'(busy), 0);
            chk("enable_at_end", int'(gen_enable), 0);
         end
      end
   end

   function automatic ev_t mk(input int kind, input int cnt, input int slot);
      ev_t e;
      e.kind = kind;
      e.cnt = cnt;
      e.slot = slot;
      return e;
   endfunction

   // Reference model: the whole chain's event list from slot, length and reply plan.
   task automatic model(input int slot, input int n, input int plan[$]);
      int k, idx, r;
      bit fin, adv;
      if (slot == 3 || n == 0) begin
         exp_q.push_back(mk(EV_ERR, 0, 0));
         return;
      end
      k = 1;
      idx = 0;
      fin = 0;
      while (!fin) begin
         r = 0;
         adv = 0;
         while (!adv && !fin) begin
            exp_q.push_back(mk(EV_XFER, k, slot));
            if (plan[idx] == OC_OK || plan[idx] == OC_LATE) begin
               if (k == n) begin
                  exp_q.push_back(mk(EV_DONE, 0, 0));
                  fin = 1;
               end else begin
                  exp_q.push_back(mk(EV_ACK, k + 1, slot));
                  k++;
                  adv = 1;
               end
            end else if (r < MAXR) begin
               r++;
            end else begin
               exp_q.push_back(mk(EV_ERR, 0, 0));
               fin = 1;
            end
            idx++;
         end
      end
   endtask

   task automatic start_chain(input int slot, input int n, input int plan[$]);
      model(slot, n, plan);
      plan_q = plan;
      @(negedge clk); #1;
      slot_in = 2'(slot);
      expected_certs = 8'(n);
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      chk("start_to_enable", int'(gen_enable), (slot < 3) ? 1 : 0);
      chk("busy_after_start", int'(busy), (slot < 3) ? 1 : 0);
   endtask

   task automatic wait_chain(input bit mid_start);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || busy) && c < BUDGET) begin
         if (mid_start && c == 1 && busy) begin
            slot_in = 2'd3;
            start = 1'b1;
         end else start = 1'b0;
         @(negedge clk); #1;
         c++;
      end
      start = 1'b0;
      chk("chain_events_left", exp_q.size(), 0);
      if (exp_q.size() != 0) exp_q.delete();
   endtask

   task automatic run_chain(input int slot, input int n, input int plan[$], input bit mid_start);
      start_chain(slot, n, plan);
      wait_chain(mid_start);
   endtask

   initial begin
      int plan[$];
      int a0, d0, x0, held, c;
      reset = 1'b1;
      start = 1'b0;
      hold_ready = 1'b0;
      slot_in = 2'd0;
      expected_certs = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_enable", int'(gen_enable), 0);
      chk("rst_msg_valid", int'(msg_valid), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_ack_in", int'(gen_ack_in), 0);
      chk("rst_counter", int'(gen_counter), 0);
      chk("rst_slot", int'(gen_slot), 0);
      #1 reset = 1'b0;

      // Slot 1, four certificates, all good.
      a0 = n_ack; d0 = n_done;
      plan = '{OC_OK, OC_OK, OC_OK, OC_OK};
      run_chain(1, 4, plan, 1'b0);
      chk("t1_ack_in_pulses", n_ack - a0, 3);
      chk("t1_done_pulses", n_done - d0, 1);

      // Slot 2, NAK once on certificate 3.
      a0 = n_ack; x0 = n_xfer;
      plan = '{OC_OK, OC_OK, OC_NAK, OC_OK, OC_OK, OC_OK};
      run_chain(2, 5, plan, 1'b0);
      chk("t2_ack_in_pulses", n_ack - a0, 4);
      chk("t2_transfers", n_xfer - x0, 6);

      // Slot 0, certificate 2 never answered: three sends, then error.
      x0 = n_xfer;
      plan = '{OC_OK, OC_TO, OC_TO, OC_TO};
      run_chain(0, 3, plan, 1'b0);
      chk("t3_transfers", n_xfer - x0, 4);
      chk("t3_timeout_latency", last_err_cyc - last_xfer_cyc, TO + 1);
      chk("t3_enable_low", int'(gen_enable), 0);

      // Bad slot, then a start while busy.
      plan = '{OC_OK};
      run_chain(3, 1, plan, 1'b0);
      chk("t4_busy_low", int'(busy), 0);
      plan = '{OC_OK, OC_OK};
      run_chain(1, 2, plan, 1'b1);

      // Transmitter stalls for 50 cycles.
      hold_ready = 1'b1;
      plan = '{OC_OK};
      start_chain(0, 1, plan);
      c = 0;
      while (!msg_valid && c < 100) begin
         @(negedge clk); #1;
         c++;
      end
      held = 0;
      repeat (50) begin
         if (msg_valid) held++;
         @(negedge clk); #1;
      end
      chk("t5_msg_valid_held", held, 50);
      hold_ready = 1'b0;
      wait_chain(1'b0);

      // Reset while waiting for a reply.
      plan = '{OC_TO, OC_TO, OC_TO};
      x0 = n_xfer;
      start_chain(2, 2, plan);
      c = 0;
      while (n_xfer == x0 && c < 200) begin
         @(negedge clk); #1;
         c++;
      end
      chk("t5_reached_wait", n_xfer - x0, 1);
      repeat (10) @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("t5r_busy", int'(busy), 0);
      chk("t5r_enable", int'(gen_enable), 0);
      chk("t5r_msg_valid", int'(msg_valid), 0);
      chk("t5r_done", int'(done), 0);
      chk("t5r_error", int'(error), 0);
      chk("t5r_counter", int'(gen_counter), 0);
      #1 reset = 1'b0;
      exp_q.delete();
      plan_q.delete();
      repeat (10) @(negedge clk);

      // Good reply on the exact timeout cycle.
      x0 = n_xfer;
      plan = '{OC_LATE, OC_OK};
      run_chain(1, 2, plan, 1'b0);
      chk("t6_transfers", n_xfer - x0, 2);

      // Randomized chains.
      for (int i = 0; i < 20; i++) begin
         int s, slot, n, r;
         int rp[$];
         s = $urandom_range(0, 7);
         slot = (s == 7) ? 3 : (s % 3);
         n = $urandom_range(0, 5);
         for (int j = 0; j < (n + 1) * (MAXR + 1); j++) begin
            r = $urandom_range(0, 99);
            rp.push_back((r < 75) ? OC_OK : (r < 93) ? OC_NAK : (r < 97) ? OC_TO : OC_LATE);
         end
         run_chain(slot, n, rp, 1'b0);
         repeat (3) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
